// File: rtl/load_store_ctrl.sv
// load_store_ctrl: sequences one load or store at a time onto a ready/valid data-memory
// port. It stalls the core while the access is in flight and returns the extended load
// data to writeback. Misaligned, illegal-size and timed-out accesses end with an error pulse.
module load_store_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_we,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_wb_data;
    logic [1:0]        r_err_code;

    logic              w_misalign;
    logic              w_illegal;
    logic              w_accept;
    logic              w_timeout;
    logic [31:0]       w_load_data;

    // Replicate store data across all lanes so the strobes alone select the bytes written.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: lane_wdata = {4{d[7:0]}};
            SZ_HALF: lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_strb = 4'b0001 << off;
            SZ_HALF: lane_strb = 4'b0011 << off;
            SZ_WORD: lane_strb = 4'b1111;
            default: lane_strb = 4'b0000;
        endcase
    endfunction

    // Shift the addressed lane down, then sign- or zero-extend it to 32 bits.
    function automatic logic [31:0] format_load(input logic [1:0] size, input logic uns,
                                                input logic [1:0] off, input logic [31:0] rdata);
        logic [15:0] sh;
        sh = 16'(rdata >> {off, 3'b000});
        case (size)
            SZ_BYTE: format_load = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: format_load = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: format_load = rdata;
        endcase
    endfunction

    assign w_misalign  = ((ex_size == SZ_HALF) && ex_addr[0]) ||
                         ((ex_size == SZ_WORD) && (ex_addr[1:0] != 2'b00));
    assign w_illegal   = (ex_size == 2'b11);
    assign w_accept    = (r_state == S_IDLE) && ex_valid;
    assign w_timeout   = (r_state == S_BUSY) && !mem_ready && (r_cnt == CNT_LAST);
    assign w_load_data = format_load(r_size, r_unsigned, r_addr[1:0], mem_rdata);

    assign mem_we    = r_we;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign wb_data   = r_wb_data;
    assign err_code  = r_err_code;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; a mem_ready in the last BUSY cycle beats the timeout.
    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        mem_req      = 1'b0;
        wb_valid     = 1'b0;
        err          = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                stall = ex_valid;
                if (ex_valid) begin
                    w_next_state = (w_misalign || w_illegal) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready || w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                wb_valid     = 1'b1;
                err          = |r_err_code;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // BUSY-cycle counter, cleared whenever the FSM is not staying in BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == S_BUSY) && (w_next_state == S_BUSY)) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Request latch on accept, and result/error capture when the access resolves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_wb_data  <= '0;
            r_err_code <= CODE_NONE;
        end else if (w_accept) begin
            r_we       <= ex_we;
            r_addr     <= ex_addr;
            r_wdata    <= lane_wdata(ex_size, ex_wdata);
            r_wstrb    <= ex_we ? lane_strb(ex_size, ex_addr[1:0]) : 4'b0000;
            r_size     <= ex_size;
            r_unsigned <= ex_unsigned;
            if (w_illegal) begin
                r_wb_data  <= '0;
                r_err_code <= CODE_ILLEGAL;
            end else if (w_misalign) begin
                r_wb_data  <= '0;
                r_err_code <= CODE_MISALIGN;
            end
        end else if (r_state == S_BUSY) begin
            if (mem_ready) begin
                r_wb_data  <= r_we ? 32'h0 : w_load_data;
                r_err_code <= CODE_NONE;
            end else if (w_timeout) begin
                r_wb_data  <= '0;
                r_err_code <= CODE_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Scoreboard bench for load_store_ctrl: each request pushes its expected writeback,
// and a monitor pops and compares on every wb_valid pulse.
module tb_load_store_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_we;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        err;
    logic [1:0]  err_code;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  code;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  last_code = 2'b00;

    load_store_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: b = rd[7:0];
            2'd1: b = rd[15:8];
            2'd2: b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        if (size == 2'd0)      m_load = uns ? {24'h0, b} : 32'($signed(b));
        else if (size == 2'd1) m_load = uns ? {16'h0, h} : 32'($signed(h));
        else                   m_load = rd;
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'd2) m_strb = 4'hF;
        else if (size == 2'd1) m_strb = off[1] ? 4'hC : 4'h3;
        else case (off)
            2'd0: m_strb = 4'h1;
            2'd1: m_strb = 4'h2;
            2'd2: m_strb = 4'h4;
            default: m_strb = 4'h8;
        endcase
    endfunction

    // Writeback monitor: compares each pulse with the oldest expectation; checks code hold otherwise.
    always @(negedge clk) begin
        if (rst) begin
            last_code = 2'b00;
        end else if (wb_valid) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_err", 32'(err), 32'(e.code != 2'b00));
                chk("wb_err_code", 32'(err_code), 32'(e.code));
                last_code = e.code;
            end
        end else begin
            chk("err_idle", 32'(err), 32'd0);
            chk("err_code_hold", 32'(err_code), 32'(last_code));
        end
    end

    // One access from an IDLE negedge; rdy_at = BUSY cycle (1-based) carrying mem_ready, 0 = never.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input int rdy_at,
                          input logic [31:0] rdata, input logic keep);
        exp_t e;
        int   exp_busy, n_busy, n_stall, k_done;
        logic done;
        logic [1:0] code;
        code = 2'b00;
        if (size == 2'd3) code = 2'b10;
        else if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) code = 2'b01;
        else if (rdy_at == 0) code = 2'b11;
        exp_busy = (code == 2'b01 || code == 2'b10) ? 0 : (rdy_at == 0 ? TMO : rdy_at);
        e.code = code;
        e.data = (code != 2'b00 || we) ? 32'h0 : m_load(size, uns, addr[1:0], rdata);
        sb_q.push_back(e);

        ex_valid = 1'b1; ex_we = we; ex_addr = addr; ex_wdata = wdata;
        ex_size = size; ex_unsigned = uns; mem_ready = 1'b0;
        #1;
        chk("stall_accept", 32'(stall), 32'd1);
        @(negedge clk);
        n_busy = 0; n_stall = 1; k_done = 0; done = 1'b0;
        for (int k = 1; k <= TMO + 4 && !done; k++) begin
            if (wb_valid) begin
                done = 1'b1;
                k_done = k;
            end else begin
                if (mem_req) n_busy++;
                if (stall) n_stall++;
                if (k == 1 && mem_req) begin
                    chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                    chk("mem_we", 32'(mem_we), 32'(we));
                    chk("mem_wstrb", 32'(mem_wstrb), we ? 32'(m_strb(size, addr[1:0])) : 32'd0);
                    if (we) chk("mem_wdata", mem_wdata,
                                size == 2'd0 ? {4{wdata[7:0]}} :
                                size == 2'd1 ? {2{wdata[15:0]}} : wdata);
                end
                mem_ready = (k == rdy_at);
                mem_rdata = (k == rdy_at) ? rdata : $urandom;
                @(negedge clk);
            end
        end
        mem_ready = 1'b0;
        if (!done) chk("wb_never_seen", 32'd0, 32'd1);
        chk("busy_cycles", 32'(n_busy), 32'(exp_busy));
        chk("stall_cycles", 32'(n_stall), 32'(exp_busy + 1));
        chk("wb_latency", 32'(k_done), 32'(exp_busy + 1));
        chk("stall_resp", 32'(stall), 32'd0);
        chk("req_resp", 32'(mem_req), 32'd0);
        if (!keep) ex_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_we = 1'b0; ex_addr = '0; ex_wdata = '0;
        ex_size = 2'b00; ex_unsigned = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        access(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 3, 32'hDEADBEEF, 1'b0);   // LW
        access(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 1, 32'h80FF1234, 1'b0);   // LB
        access(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 2, 32'h80FF1234, 1'b0);   // LBU
        access(1'b0, 32'h102, 32'h0, 2'd1, 1'b0, 1, 32'h80FF1234, 1'b0);   // LH
        access(1'b0, 32'h102, 32'h0, 2'd1, 1'b1, 1, 32'h80FF1234, 1'b0);   // LHU
        access(1'b0, 32'h100, 32'h0, 2'd0, 1'b0, 2, 32'h80FF1234, 1'b0);   // LB lane 0
        access(1'b1, 32'h202, 32'h000000A5, 2'd0, 1'b0, 1, 32'h0, 1'b0);   // SB
        access(1'b1, 32'h202, 32'h0000A5A5, 2'd1, 1'b0, 2, 32'h0, 1'b0);   // SH
        access(1'b1, 32'h204, 32'h12345678, 2'd2, 1'b0, 1, 32'h0, 1'b0);   // SW
        access(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 1, 32'h0, 1'b0);          // LW misaligned
        access(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 1, 32'h0, 1'b0);          // illegal size
        access(1'b1, 32'h201, 32'hFFFF, 2'd1, 1'b0, 1, 32'h0, 1'b0);       // SH misaligned
        access(1'b0, 32'h400, 32'h0, 2'd2, 1'b0, 0, 32'h0, 1'b0);          // timeout
        access(1'b0, 32'h404, 32'h0, 2'd2, 1'b0, TMO, 32'hCAFEF00D, 1'b0); // ready on last cycle

        // Back-to-back: ex_valid stays high through RESP; next request taken in the following IDLE.
        access(1'b0, 32'h500, 32'h0, 2'd2, 1'b0, 1, 32'h11112222, 1'b1);
        access(1'b0, 32'h501, 32'h0, 2'd0, 1'b1, 1, 32'h0000AB00, 1'b1);
        access(1'b0, 32'h504, 32'h0, 2'd2, 1'b0, 2, 32'h33334444, 1'b0);

        // Reset during BUSY aborts the access with no writeback (after an error so err_code is nonzero).
        access(1'b0, 32'h603, 32'h0, 2'd1, 1'b0, 1, 32'h0, 1'b0);
        ex_valid = 1'b1; ex_we = 1'b0; ex_addr = 32'h300; ex_size = 2'd2; mem_ready = 1'b0;
        @(negedge clk);
        chk("abort_req_busy", 32'(mem_req), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_wb_valid", 32'(wb_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_wb", 32'(wb_valid), 32'd0);
            chk("abort_idle_req", 32'(mem_req), 32'd0);
        end

        // Random aligned loads and stores with varying memory latency.
        for (int i = 0; i < 10; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 2));
            a = $urandom;
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            access(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
                   $urandom_range(1, 5), $urandom, 1'b0);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
